// File: rtl/pmem_arbiter.sv
// Purpose : arbitrates icache and dcache line transactions onto one physical-memory port.
// Latency : one IDLE arbitration cycle before the pmem strobe, then memory latency; resp is same-cycle as pmem_resp.
// Backpressure: a losing client holds its strobe until granted; no queuing, one whole transaction at a time.
//
// Ports:
//   clk, reset                          - single clock, synchronous active-high reset
//   icache_read/address -> rdata/resp   - icache line-fill client
//   dcache_read/write/address/wdata     - dcache fill / victim-writeback client
//     -> dcache_rdata/resp
//   pmem_read/write/address/wdata       - physical-memory request side
//   pmem_rdata/resp                     - physical-memory response side
//
// Build option: define ARB_ROUND_ROBIN_EN to break ties against the last granted
// client; left undefined, the dcache always wins a tie.

module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,

    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_e state_q;
    state_e state_d;
    logic   last_grant_q;
    logic   last_grant_d;

    logic   icache_req;
    logic   dcache_req;
    logic   tie_pick_d;    // 1: dcache wins a simultaneous request

    assign icache_req = icache_read;
    assign dcache_req = dcache_read | dcache_write;

    // Read data is broadcast; only the matching resp qualifies it.
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

    // Tie-break policy.
    always_comb begin
        tie_pick_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        // Favour whichever client was not served last; last_grant resets to
        // icache so the very first tie goes to the dcache.
        tie_pick_d = (last_grant_q == GRANT_I);
`else
        // Fixed priority: dcache misses stall the pipeline harder, so it wins.
        tie_pick_d = 1'b1;
`endif
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;

        case (state_q)
            IDLE: begin
                // pmem_resp is deliberately not looked at here: a stray or
                // post-reset response must not be forwarded to anyone.
                if (icache_req && dcache_req) begin
                    state_d = tie_pick_d ? SERVE_D : SERVE_I;
                end else if (dcache_req) begin
                    state_d = SERVE_D;
                end else if (icache_req) begin
                    state_d = SERVE_I;
                end
            end

            SERVE_I: begin
                pmem_read    = icache_read;
                pmem_address = icache_address;
                if (pmem_resp) begin
                    icache_resp  = 1'b1;
                    last_grant_d = GRANT_I;
                    state_d      = IDLE;
                end else if (!icache_req) begin
                    // Client withdrew: abandon without a resp and without
                    // counting it as a grant.
                    state_d = IDLE;
                end
            end

            SERVE_D: begin
                // A writeback must complete before the fill of the same line
                // slot, so write takes precedence when both strobes are up.
                pmem_write   = dcache_write;
                pmem_read    = dcache_read & ~dcache_write;
                pmem_address = dcache_address;
                pmem_wdata   = dcache_wdata;
                if (pmem_resp) begin
                    dcache_resp  = 1'b1;
                    last_grant_d = GRANT_D;
                    state_d      = IDLE;
                end else if (!dcache_req) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset is synchronous, so the state flop may still hold a SERVE
        // state during the reset cycle; force the memory side quiet anyway.
        if (reset) begin
            pmem_read    = 1'b0;
            pmem_write   = 1'b0;
            pmem_address = '0;
            pmem_wdata   = '0;
            icache_resp  = 1'b0;
            dcache_resp  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge of the same cycle.

module tb_pmem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    localparam logic [LW-1:0] LINE_A5 = {16{8'hA5}};
    localparam logic [LW-1:0] LINE_11 = {16{8'h11}};
    localparam logic [LW-1:0] LINE_3C = {16{8'h3C}};

    logic          clk;
    logic          reset;
    logic          icache_read;
    logic [AW-1:0] icache_address;
    logic [LW-1:0] icache_rdata;
    logic          icache_resp;
    logic          dcache_read;
    logic          dcache_write;
    logic [AW-1:0] dcache_address;
    logic [LW-1:0] dcache_wdata;
    logic [LW-1:0] dcache_rdata;
    logic          dcache_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int vec_cnt;
    int err_cnt;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_read    = 1'b0;
        icache_address = '0;
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = '0;
        dcache_wdata   = '0;
        pmem_rdata     = '0;
        pmem_resp      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        clear_inputs();
        icache_read    = 1'b1;
        icache_address = 16'h1230;
        dcache_read    = 1'b1;
        dcache_write   = 1'b1;
        dcache_address = 16'h4560;
        dcache_wdata   = LINE_11;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0)
            $display("FAIL reset_strobes: read=%b write=%b, required 0 0", pmem_read, pmem_write);
        else if (icache_resp !== 1'b0 || dcache_resp !== 1'b0)
            $display("FAIL reset_resp: iresp=%b dresp=%b, required 0 0", icache_resp, dcache_resp);
        else if (pmem_address !== 16'h0 || pmem_wdata !== '0)
            $display("FAIL reset_addr: addr=%h, required 0", pmem_address);
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || icache_resp !== 1'b0 ||
            dcache_resp !== 1'b0 || pmem_address !== 16'h0 || pmem_wdata !== '0) err_cnt++;

        // First cycle out of reset: IDLE, and a stray pmem_resp is ignored.
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_3C;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL post_reset_idle: read=%b write=%b iresp=%b dresp=%b, required all 0",
                     pmem_read, pmem_write, icache_resp, dcache_resp);
        end
        next_cycle();
        pmem_resp = 1'b0;
    endtask

    task automatic test_icache_fill();
        icache_read    = 1'b1;
        icache_address = 16'h1230;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0) begin
            err_cnt++;
            $display("FAIL ifill_bubble: pmem_read=%b, required 0", pmem_read);
        end
        next_cycle();
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230 || icache_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL ifill_strobe: read=%b write=%b addr=%h iresp=%b, required 1 0 1230 0",
                     pmem_read, pmem_write, pmem_address, icache_resp);
        end
        next_cycle();
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_A5;
        @(negedge clk);
        vec_cnt++;
        if (icache_resp !== 1'b1 || dcache_resp !== 1'b0 || icache_rdata !== LINE_A5 || dcache_rdata !== LINE_A5) begin
            err_cnt++;
            $display("FAIL ifill_resp: iresp=%b dresp=%b irdata=%h, required 1 0 %h",
                     icache_resp, dcache_resp, icache_rdata, LINE_A5);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0 || icache_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL ifill_idle: read=%b iresp=%b, required 0 0", pmem_read, icache_resp);
        end
        next_cycle();
    endtask

    task automatic test_dcache_write();
        dcache_write   = 1'b1;
        dcache_address = 16'h4560;
        dcache_wdata   = LINE_11;
        @(negedge clk);
        vec_cnt++;
        if (pmem_write !== 1'b0) begin
            err_cnt++;
            $display("FAIL dwb_bubble: pmem_write=%b, required 0", pmem_write);
        end
        next_cycle();
        @(negedge clk);
        vec_cnt++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h4560 || pmem_wdata !== LINE_11) begin
            err_cnt++;
            $display("FAIL dwb_strobe: write=%b read=%b addr=%h wdata=%h, required 1 0 4560 %h",
                     pmem_write, pmem_read, pmem_address, pmem_wdata, LINE_11);
        end
        // Both dcache strobes high: write must win.
        next_cycle();
        dcache_read = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin
            err_cnt++;
            $display("FAIL dwb_write_wins: write=%b read=%b, required 1 0", pmem_write, pmem_read);
        end
        next_cycle();
        dcache_read = 1'b0;
        pmem_resp   = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (dcache_resp !== 1'b1 || icache_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL dwb_resp: dresp=%b iresp=%b, required 1 0", dcache_resp, icache_resp);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vec_cnt++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || dcache_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL dwb_idle: write=%b read=%b dresp=%b, required 0 0 0", pmem_write, pmem_read, dcache_resp);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_addr2;
        logic          exp_i2;
`ifdef ARB_ROUND_ROBIN_EN
        exp_addr2 = 16'h1230;
        exp_i2    = 1'b1;
`else
        exp_addr2 = 16'h7770;
        exp_i2    = 1'b0;
`endif
        do_reset();
        icache_read    = 1'b1;
        icache_address = 16'h1230;
        dcache_read    = 1'b1;
        dcache_address = 16'h7770;
        next_cycle();
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_3C;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h7770 || dcache_resp !== 1'b1 || icache_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL tie1: read=%b addr=%h dresp=%b iresp=%b, required 1 7770 1 0",
                     pmem_read, pmem_address, dcache_resp, icache_resp);
        end
        next_cycle();
        pmem_resp = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            err_cnt++;
            $display("FAIL tie_gap: read=%b write=%b, required 0 0", pmem_read, pmem_write);
        end
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_address !== exp_addr2 || icache_resp !== exp_i2 || dcache_resp !== ~exp_i2) begin
            err_cnt++;
            $display("FAIL tie2: read=%b addr=%h iresp=%b dresp=%b, required 1 %h %b %b",
                     pmem_read, pmem_address, icache_resp, dcache_resp, exp_addr2, exp_i2, ~exp_i2);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0 || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL tie_end: read=%b iresp=%b dresp=%b, required 0 0 0", pmem_read, icache_resp, dcache_resp);
        end
        next_cycle();
    endtask

    task automatic test_wb_then_fill();
        logic [AW-1:0] exp_a2;
        logic [AW-1:0] exp_a3;
        logic          i_second;
`ifdef ARB_ROUND_ROBIN_EN
        exp_a2   = 16'h1230;
        exp_a3   = 16'h7770;
        i_second = 1'b1;
`else
        exp_a2   = 16'h7770;
        exp_a3   = 16'h1230;
        i_second = 1'b0;
`endif
        do_reset();
        dcache_write   = 1'b1;
        dcache_address = 16'h4560;
        dcache_wdata   = LINE_11;
        icache_read    = 1'b1;
        icache_address = 16'h1230;
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h4560 || dcache_resp !== 1'b1) begin
            err_cnt++;
            $display("FAIL wbf_write: write=%b read=%b addr=%h dresp=%b, required 1 0 4560 1",
                     pmem_write, pmem_read, pmem_address, dcache_resp);
        end
        // dcache swaps to its fill request during the IDLE gap.
        next_cycle();
        pmem_resp      = 1'b0;
        dcache_write   = 1'b0;
        dcache_read    = 1'b1;
        dcache_address = 16'h7770;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            err_cnt++;
            $display("FAIL wbf_gap1: read=%b write=%b, required 0 0", pmem_read, pmem_write);
        end
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== exp_a2 || icache_resp !== i_second) begin
            err_cnt++;
            $display("FAIL wbf_second: read=%b write=%b addr=%h iresp=%b, required 1 0 %h %b",
                     pmem_read, pmem_write, pmem_address, icache_resp, exp_a2, i_second);
        end
        next_cycle();
        pmem_resp = 1'b0;
        if (i_second) icache_read = 1'b0;
        else          dcache_read = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0) begin
            err_cnt++;
            $display("FAIL wbf_gap2: read=%b, required 0", pmem_read);
        end
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_address !== exp_a3 || dcache_resp !== i_second || icache_resp !== ~i_second) begin
            err_cnt++;
            $display("FAIL wbf_third: read=%b addr=%h dresp=%b iresp=%b, required 1 %h %b %b",
                     pmem_read, pmem_address, dcache_resp, icache_resp, exp_a3, i_second, ~i_second);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_abort();
        icache_read    = 1'b1;
        icache_address = 16'h2340;
        next_cycle();
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h2340) begin
            err_cnt++;
            $display("FAIL abort_grant: read=%b addr=%h, required 1 2340", pmem_read, pmem_address);
        end
        next_cycle();
        icache_read = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0 || icache_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_drop: read=%b iresp=%b, required 0 0", pmem_read, icache_resp);
        end
        // Now IDLE: a fresh dcache fill needs the normal bubble, then is served.
        next_cycle();
        dcache_read    = 1'b1;
        dcache_address = 16'h5550;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0 || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_idle: read=%b iresp=%b dresp=%b, required 0 0 0", pmem_read, icache_resp, dcache_resp);
        end
        next_cycle();
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_A5;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h5550 || dcache_resp !== 1'b1 ||
            icache_resp !== 1'b0 || dcache_rdata !== LINE_A5) begin
            err_cnt++;
            $display("FAIL abort_next_d: read=%b addr=%h dresp=%b iresp=%b, required 1 5550 1 0",
                     pmem_read, pmem_address, dcache_resp, icache_resp);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        icache_read    = 1'b1;
        icache_address = 16'h1230;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0 || pmem_address !== 16'h0) begin
            err_cnt++;
            $display("FAIL rstmid_during: read=%b addr=%h, required 0 0", pmem_read, pmem_address);
        end
        next_cycle();
        reset       = 1'b0;
        icache_read = 1'b0;
        pmem_resp   = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (pmem_read !== 1'b0 || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL rstmid_after: read=%b iresp=%b dresp=%b, required 0 0 0", pmem_read, icache_resp, dcache_resp);
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_icache_fill();
        test_dcache_write();
        test_back_to_back();
        test_wb_then_fill();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
